// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - byte stream input and instruction memory write port of the loader
interface instr_loader_if #(
   parameter int A_length = 12,
   parameter int D_length = 8
);
   logic                in_valid;
   logic [7:0]          in_data;
   logic                in_ready;
   logic                WE;
   logic [A_length-1:0] WA;
   logic [D_length-1:0] WD;

   modport slave (
      input  in_valid, in_data,
      output in_ready, WE, WA, WD
   );

   modport master (
      output in_valid, in_data,
      input  in_ready, WE, WA, WD
   );
endinterface

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - framed byte-stream loader writing the instruction memory
// Frame: 16-bit length (MSB first), payload bytes, XOR checksum; CPU held in reset until a good load.
module instr_loader #(
   parameter int A_length = 12,
   parameter int D_length = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           abort,
   output logic           busy,
   output logic           done,
   output logic           error,
   output logic           cpu_hold,
   instr_loader_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHECK} state_t;

   localparam logic [15:0] MAX_LEN = 16'(2 ** A_length);

   state_t              state, state_d;
   logic [15:0]         len, len_d;
   logic [A_length-1:0] addr, addr_d;
   logic [12:0]         count, count_d;
   logic [7:0]          csum, csum_d;
   logic                we_d;
   logic [A_length-1:0] wa_d;
   logic [D_length-1:0] wd_d;
   logic                busy_d, done_d, error_d, hold_d;
   logic                accept;
   logic [15:0]         full_len;

   assign bus.in_ready = (state != IDLE);
   assign accept       = bus.in_valid & bus.in_ready;
   assign full_len     = {len[15:8], bus.in_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         len      <= '0;
         addr     <= '0;
         count    <= '0;
         csum     <= '0;
         bus.WE   <= 1'b0;
         bus.WA   <= '0;
         bus.WD   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         cpu_hold <= 1'b0;
      end else begin
         state    <= state_d;
         len      <= len_d;
         addr     <= addr_d;
         count    <= count_d;
         csum     <= csum_d;
         bus.WE   <= we_d;
         bus.WA   <= wa_d;
         bus.WD   <= wd_d;
         busy     <= busy_d;
         done     <= done_d;
         error    <= error_d;
         cpu_hold <= hold_d;
      end
   end

   always_comb begin
      state_d = state;
      len_d   = len;
      addr_d  = addr;
      count_d = count;
      csum_d  = csum;
      we_d    = 1'b0;
      wa_d    = bus.WA;
      wd_d    = bus.WD;
      busy_d  = busy;
      done_d  = done;
      error_d = error;
      hold_d  = cpu_hold;

      if (state == IDLE) begin
         if (start) begin
            state_d = LEN_HI;
            done_d  = 1'b0;
            error_d = 1'b0;
            hold_d  = 1'b1;
            busy_d  = 1'b1;
         end
      end else if (abort) begin
         // abort outranks a same-cycle accept, so that byte is dropped
         state_d = IDLE;
         error_d = 1'b1;
         hold_d  = 1'b1;
         busy_d  = 1'b0;
      end else if (accept) begin
         case (state)
            LEN_HI: begin
               len_d   = {bus.in_data, 8'h00};
               state_d = LEN_LO;
            end
            LEN_LO: begin
               len_d = full_len;
               if (full_len == 16'd0 || full_len > MAX_LEN) begin
                  state_d = IDLE;
                  error_d = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = DATA;
                  addr_d  = '0;
                  count_d = '0;
                  csum_d  = '0;
               end
            end
            DATA: begin
               we_d    = 1'b1;
               wa_d    = addr;
               wd_d    = D_length'(bus.in_data);
               addr_d  = addr + 1'b1;
               count_d = count + 1'b1;
               csum_d  = csum ^ bus.in_data;
               if ({3'b000, count} == len - 16'd1)
                  state_d = CHECK;
            end
            CHECK: begin
               state_d = IDLE;
               busy_d  = 1'b0;
               if (bus.in_data == csum) begin
                  done_d = 1'b1;
                  hold_d = 1'b0;
               end else begin
                  error_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader
module tb_instr_loader;
   logic clk = 1'b0;
   logic rst_n, start, abort;
   logic busy, done, error, cpu_hold;
   int   checks = 0;
   int   errors = 0;

   instr_loader_if #(.A_length(12), .D_length(8)) bus ();

   instr_loader #(.A_length(12), .D_length(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   // write-port recorder, sampled on the falling edge
   logic       mon_clr = 1'b1;
   int         we_cnt, seq_err;
   logic [11:0] exp_wa, last_wa;
   logic [7:0] mem [0:4095];

   always @(negedge clk) begin
      if (mon_clr) begin
         we_cnt  = 0;
         seq_err = 0;
         exp_wa  = 12'h000;
         last_wa = 12'h000;
      end else if (bus.WE === 1'b1) begin
         we_cnt++;
         if (bus.WA !== exp_wa) seq_err++;
         last_wa = bus.WA;
         exp_wa  = bus.WA + 12'h001;
         mem[bus.WA] = bus.WD;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      @(posedge clk); mon_clr = 1'b1;
      @(posedge clk); mon_clr = 1'b0;
      @(negedge clk);
   endtask

   // called at a falling edge; returns at the falling edge after the accepting edge
   task automatic send(input logic [7:0] b);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic send_bp(input logic [7:0] b);
      logic v;
      for (int t = 0; t < 64; t++) begin
         v = 1'($urandom_range(0, 1));
         bus.in_valid = v;
         bus.in_data  = v ? b : 8'($urandom);
         @(posedge clk); @(negedge clk);
         if (v) return;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
   endtask

   task automatic idle_in();
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " WE"}, {31'd0, bus.WE}, 32'd0);
      check({tag, " WA"}, {20'd0, bus.WA}, 32'd0);
      check({tag, " WD"}, {24'd0, bus.WD}, 32'd0);
      check({tag, " flags"}, {28'd0, busy, done, error, cpu_hold}, 32'd0);
      check({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   logic [7:0] prog [0:7];
   logic [7:0] b, cs;

   initial begin
      prog[0] = 8'h00; prog[1] = 8'h50; prog[2] = 8'h00; prog[3] = 8'h93;
      prog[4] = 8'h01; prog[5] = 8'h00; prog[6] = 8'h01; prog[7] = 8'h13;

      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 1'($urandom); abort = 1'($urandom);
         bus.in_valid = 1'($urandom); bus.in_data = 8'($urandom);
      end
      #1;
      check_all_zero("reset");
      start = 1'b0; abort = 1'b0; idle_in();
      @(negedge clk); rst_n = 1'b1;
      clear_mon();
      check_all_zero("after release");

      // good load
      do_start();
      check("start busy", {30'd0, busy, cpu_hold}, 32'h3);
      send(8'h00); send(8'h08);
      send(prog[0]);
      check("latency WE", {31'd0, bus.WE}, 32'd1);
      check("latency WA/WD", {bus.WA, bus.WD}, {12'h000, 8'h00});
      for (int i = 1; i < 8; i++) send(prog[i]);
      send(8'hD0);
      idle_in();
      check("good flags", {28'd0, busy, done, error, cpu_hold}, 32'b0100);
      check("good we_cnt", we_cnt, 32'd8);
      check("good seq", seq_err, 32'd0);
      check("good fetch", {mem[0], mem[1], mem[2], mem[3]}, 32'h00500093);
      check("good idle ready", {31'd0, bus.in_ready}, 32'd0);

      // bad checksum
      clear_mon();
      do_start();
      send(8'h00); send(8'h08);
      for (int i = 0; i < 8; i++) send(prog[i]);
      send(8'hD1);
      idle_in();
      check("badcs flags", {28'd0, busy, done, error, cpu_hold}, 32'b0011);
      check("badcs we_cnt", we_cnt, 32'd8);

      // bad length 0x1001 and 0x0000
      clear_mon();
      do_start();
      send(8'h10); send(8'h01);
      idle_in();
      check("len1001 flags", {28'd0, busy, done, error, cpu_hold}, 32'b0011);
      check("len1001 idle", {31'd0, bus.in_ready}, 32'd0);
      do_start();
      send(8'h00); send(8'h00);
      idle_in();
      @(negedge clk);
      check("len0000 flags", {28'd0, busy, done, error, cpu_hold}, 32'b0011);
      check("badlen no writes", we_cnt, 32'd0);

      // full 4096-byte image with random in_valid gaps
      clear_mon();
      do_start();
      send_bp(8'h10); send_bp(8'h00);
      cs = 8'h00;
      for (int k = 0; k < 4096; k++) begin
         b = 8'(k) ^ 8'(k >> 8) ^ 8'h5A;
         cs ^= b;
         send_bp(b);
      end
      send_bp(cs);
      idle_in();
      check("full we_cnt", we_cnt, 32'd4096);
      check("full last WA", {20'd0, last_wa}, 32'hFFF);
      check("full seq", seq_err, 32'd0);
      check("full flags", {28'd0, busy, done, error, cpu_hold}, 32'b0100);
      check("full mem[0xABC]", {24'd0, mem[12'hABC]}, {24'd0, 8'hBC ^ 8'h0A ^ 8'h5A});

      // abort together with the 3rd payload byte
      clear_mon();
      do_start();
      send(8'h00); send(8'h08);
      send(prog[0]); send(prog[1]);
      abort = 1'b1;
      send(prog[2]);
      abort = 1'b0;
      idle_in();
      @(negedge clk); @(negedge clk);
      check("abort we_cnt", we_cnt, 32'd2);
      check("abort flags", {28'd0, busy, done, error, cpu_hold}, 32'b0011);

      // reset during DATA
      do_start();
      send(8'h00); send(8'h08);
      send(prog[0]); send(prog[1]); send(prog[2]);
      rst_n = 1'b0;
      #1;
      check_all_zero("midload reset");
      idle_in();
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check("post reset flags", {28'd0, busy, done, error, cpu_hold}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/instr_loader.md
# instr_loader

Byte-stream program loader that writes an instruction image into the byte-wide, 4096-entry instruction memory (0xBFC00000–0xBFC00FFF) through its write port. It receives a framed byte stream (length header, payload, XOR checksum) over a valid/ready handshake. It emits one memory byte write per accepted payload byte. It holds the CPU in reset until a load completes with a correct checksum.

## Interface
- A_length, 12, memory address width; memory depth 2**A_length bytes
- D_length, 8, memory data width (one byte per location)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a load; sampled only in IDLE
- abort  in  1  cancel an in-progress load
- in_valid  in  1  in_data holds a stream byte
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- WE  out  1  memory write enable, single-cycle pulse
- WA  out  A_length  memory write address
- WD  out  D_length  memory write data
- busy  out  1  load in progress
- done  out  1  sticky: last load succeeded
- error  out  1  sticky: last load failed
- cpu_hold  out  1  keep CPU in reset

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK.
- A byte is accepted on a rising edge where in_valid & in_ready. in_ready = 1 in LEN_HI, LEN_LO, DATA and CHECK; 0 in IDLE. It is decoded combinationally from state.
- IDLE: start=1 -> LEN_HI. On that edge: done=0, error=0, cpu_hold=1, busy=1.
- LEN_HI: accept -> len[15:8] captured, -> LEN_LO.
- LEN_LO: accept -> len[7:0] captured.
  - If the 16-bit length is 0 or greater than 4096 -> IDLE with error=1. No writes occur.
  - Otherwise -> DATA, with addr=0, count=0, csum=0.
- DATA: each accept registers WE=1, WA=addr, WD=in_data for the following cycle. Also addr+=1, count+=1, csum^=in_data.
  - Accepting byte number len-1 (0-based) -> CHECK.
- CHECK: accept.
  - in_data==csum -> IDLE, done=1, cpu_hold=0.
  - Otherwise -> IDLE, error=1, cpu_hold stays 1.
- Byte order is fixed: the stream carries each instruction MSB first. Stream byte k lands at address k, so a fetch at word address A reads {mem[A],mem[A+1],mem[A+2],mem[A+3]} in stream order.
- Address arithmetic:
  - addr is A_length bits and never wraps within a load, because len is at most 4096.
  - For len=4096 the last write is WA=0xFFF.
  - count is 13 bits.
- abort=1 in any non-IDLE state -> IDLE, error=1, cpu_hold=1. A WE pulse already registered still completes.
- abort wins over a simultaneous accept; that byte is not written.
- start while busy is ignored. abort in IDLE is ignored.
- cpu_hold after an error remains 1 until a successful load or reset.

## Timing
- Reset (rst_n=0, immediate):
  - state=IDLE.
  - WE=0, WA=0, WD=0.
  - busy=0, done=0, error=0, cpu_hold=0.
  - in_ready=0.
- Write latency: WE/WA/WD are valid in the cycle after the accepting edge. WE is high for exactly one cycle per payload byte.
- WA and WD hold their last values while WE=0.
- Throughput: one byte per cycle with in_valid held high. A len=N load takes N+3 accepted cycles after start.
- The final payload write (WE high) coincides with the first CHECK cycle. done/error rise on the edge that accepts the checksum byte, so the final write is already complete when done rises.
- busy falls on the same edge that sets done or error.
- in_valid gaps stall the FSM with no side effects; in_data is ignored when not accepted.
- Reset asserted mid-load aborts immediately. Memory holds a partial image, and cpu_hold=0 because the reset values apply.

## Test plan
- Reset check: hold rst_n=0 with random inputs -> all outputs 0 and in_ready=0. Release rst_n -> outputs stay 0 until start.
- Good load: start, then 00 08, 00 50 00 93 01 00 01 13, checksum D0, in_valid held high.
  - Eight WE pulses with WA 0..7 and WD matching the stream.
  - done=1, error=0, cpu_hold=0, busy=0.
  - A fetch from address 0 reads 0x00500093.
- Bad checksum: same stream with checksum D1 -> eight writes occur, then error=1, done=0, cpu_hold=1.
- Bad length: header 10 01 -> error=1 after the second header byte, no WE pulses, state IDLE. Header 00 00 gives the same result.
- Backpressure and full image: len=4096, in_valid toggled pseudo-randomly -> exactly 4096 WE pulses, WA ending at 0xFFF, no duplicate or skipped address, done=1.
- Abort and reset mid-load:
  - abort asserted together with an accepted 3rd payload byte -> only 2 WE pulses, error=1, cpu_hold=1.
  - rst_n pulsed low during DATA -> all outputs 0 immediately.
